mem_access_unit: RTL and testbench

//  MEM-stage load/store unit between the EX/MEM pipeline register and the word-wide data memory.

---
 rtl/mips_mem_pkg.sv | 62 ++++++
 rtl/mem_lane_align.sv | 46 ++++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared definitions for the MEM-stage load/store unit.
//   - access opcodes (4-bit encoding, illegal codes decode as NONE)
//   - FSM state constants for the sub-word store read-modify-write
//   - op decode struct/function and alignment helper
package mips_mem_pkg;

    localparam int OP_W = 4;
    typedef logic [OP_W-1:0] mem_op_t;

    localparam mem_op_t OP_NONE = 4'd0;
    localparam mem_op_t OP_LW   = 4'd1;
    localparam mem_op_t OP_LB   = 4'd2;
    localparam mem_op_t OP_LBU  = 4'd3;
    localparam mem_op_t OP_LH   = 4'd4;
    localparam mem_op_t OP_LHU  = 4'd5;
    localparam mem_op_t OP_SW   = 4'd6;
    localparam mem_op_t OP_SB   = 4'd7;
    localparam mem_op_t OP_SH   = 4'd8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RMW  = 1'b1;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic      load;
        logic      store;
        logic      sub_st;   // SB/SH: needs read-modify-write
        logic      sign;     // sign-extend load lane
        mem_size_e size;
    } op_dec_t;

    function automatic op_dec_t decode_op(input mem_op_t op);
        op_dec_t d;
        d = '{load: 1'b0, store: 1'b0, sub_st: 1'b0, sign: 1'b0, size: SZ_WORD};
        case (op)
            OP_LW:  begin d.load = 1'b1; d.size = SZ_WORD; end
            OP_LB:  begin d.load = 1'b1; d.size = SZ_BYTE; d.sign = 1'b1; end
            OP_LBU: begin d.load = 1'b1; d.size = SZ_BYTE; end
            OP_LH:  begin d.load = 1'b1; d.size = SZ_HALF; d.sign = 1'b1; end
            OP_LHU: begin d.load = 1'b1; d.size = SZ_HALF; end
            OP_SW:  begin d.store = 1'b1; d.size = SZ_WORD; end
            OP_SB:  begin d.store = 1'b1; d.sub_st = 1'b1; d.size = SZ_BYTE; end
            OP_SH:  begin d.store = 1'b1; d.sub_st = 1'b1; d.size = SZ_HALF; end
            default: ;  // NONE and illegal encodings: passthrough
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return lo[0];
            SZ_WORD: return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering (little-endian).
//   rdata      in   32  word read from memory
//   lane       in   2   byte offset within the word
//   size       in   2   access size (byte/half/word)
//   sign       in   1   sign-extend the selected load lane
//   wdata      in   32  store data (low byte/half used for sub-word)
//   load_data  out  32  selected lane, sign/zero-extended
//   merge_data out  32  rdata with the selected lane replaced by wdata
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  mem_size_e   size,
    input  logic        sign,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{lane, 3'b000} +: 8];
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{sign & byte_v[7]}}, byte_v};
            SZ_HALF: load_data = {{16{sign & half_v[15]}}, half_v};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merge_data = rdata;
        case (size)
            SZ_BYTE: merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (lane[1]) merge_data[31:16] = wdata[15:0];
                else         merge_data[15:0]  = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit (LW/LB/LBU/LH/LHU/SW/SB/SH).
//   clk, rst_n                  clock, async active-low reset
//   req_valid/op/addr/wdata/rd/reg_write   EX/MEM request (held while stall=1)
//   stall                       hold upstream this cycle (first cycle of SB/SH)
//   mem_read/write/addr/wdata   word-wide data memory interface
//   mem_rdata                   combinational read data
//   wb_valid/reg_write/rd/data  registered MEM/WB entry
//   addr_error, err_addr        misalignment pulse and sticky faulting address
// Sub-word stores run IDLE (read + merge into merge_q, stall) -> RMW (write
// merged word, accept) -> IDLE. Everything else completes in one cycle.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit TRAP_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    input  logic              req_reg_write,
    output logic              stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              addr_error,
    output logic [ADDR_W-1:0] err_addr
);

    op_dec_t           dec;
    logic              is_mem;
    logic              err;
    logic [ADDR_W-1:0] eff_addr;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic [0:0]        state_q, state_d;
    logic [31:0]       merge_q;
    logic              accept;

    assign dec    = decode_op(req_op);
    assign is_mem = dec.load | dec.store;
    assign err    = TRAP_ALIGN & is_mem & is_misaligned(dec.size, req_addr[1:0]);

    // Without trapping, misaligned low address bits are simply dropped.
    always_comb begin
        eff_addr = req_addr;
        if (!TRAP_ALIGN && is_mem) begin
            case (dec.size)
                SZ_HALF: eff_addr[0]   = 1'b0;
                SZ_WORD: eff_addr[1:0] = 2'b00;
                default: ;
            endcase
        end
    end

    mem_lane_align u_align (
        .rdata      (mem_rdata),
        .lane       (eff_addr[1:0]),
        .size       (dec.size),
        .sign       (dec.sign),
        .wdata      (req_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // rst_n gates the combinational outputs so nothing reaches memory in reset;
    // this is also what kills an in-flight RMW write.
    always_comb begin
        stall     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 32'h0;
        accept    = 1'b0;
        state_d   = state_q;
        if (rst_n) begin
            if (state_q == RMW) begin
                mem_write = 1'b1;
                mem_wdata = merge_q;
                accept    = req_valid;
                state_d   = IDLE;
            end else if (req_valid) begin
                if (err) begin
                    accept = 1'b1;
                end else if (dec.sub_st) begin
                    stall    = 1'b1;
                    mem_read = 1'b1;
                    state_d  = RMW;
                end else begin
                    accept   = 1'b1;
                    mem_read = dec.load;
                    if (dec.store) begin
                        mem_write = 1'b1;
                        mem_wdata = req_wdata;
                    end
                end
            end
        end
    end

    assign mem_addr = rst_n ? {eff_addr[ADDR_W-1:2], 2'b00} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            merge_q      <= 32'h0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'h0;
            addr_error   <= 1'b0;
            err_addr     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && stall) merge_q <= merge_data;
            wb_valid     <= accept;
            wb_reg_write <= accept & req_reg_write & ~dec.store & ~err;
            addr_error   <= accept & err;
            if (accept) begin
                wb_rd   <= req_rd;
                wb_data <= dec.load ? load_data : (dec.store ? 32'h0 : req_wdata);
            end
            if (accept && err) err_addr <= req_addr;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        req_reg_write;
    logic        stall, mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        wb_valid, wb_reg_write, addr_error;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, err_addr;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:63];
    logic        pl_we = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'h0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we)          mem[pl_idx] <= pl_data;
        else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end
    assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;

    mem_access_unit #(.ADDR_W(32), .TRAP_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .req_reg_write(req_reg_write), .stall(stall), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .addr_error(addr_error), .err_addr(err_addr)
    );

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic rw);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
        req_rd = rd; req_reg_write = rw;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_op = OP_NONE; req_reg_write = 1'b0;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx; pl_data = data;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(); req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        preload(6'd4, 32'h8899AABB);
        preload(6'd12, 32'h01020304);
        @(negedge clk); #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%0h want=0", wb_valid); end
        total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL rst_wb_reg_write got=%0h want=0", wb_reg_write); end
        total++; if (wb_data !== 32'h0) begin bad++; $display("FAIL rst_wb_data got=%h want=0", wb_data); end
        total++; if (addr_error !== 1'b0) begin bad++; $display("FAIL rst_addr_error got=%0h want=0", addr_error); end
        total++; if (err_addr !== 32'h0) begin bad++; $display("FAIL rst_err_addr got=%h want=0", err_addr); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h want=0", stall); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        @(negedge clk);
        drive(OP_LW, 32'h10, 32'h0, 5'd5, 1'b1);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lw_stall got=%0h want=0", stall); end
        total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL lw_mem_read got=%0h want=1", mem_read); end
        total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL lw_mem_addr got=%h want=10", mem_addr); end
        @(negedge clk);
        idle();
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL lw_wb_valid got=%0h want=1", wb_valid); end
        total++; if (wb_reg_write !== 1'b1) begin bad++; $display("FAIL lw_wb_reg_write got=%0h want=1", wb_reg_write); end
        total++; if (wb_rd !== 5'd5) begin bad++; $display("FAIL lw_wb_rd got=%0d want=5", wb_rd); end
        total++; if (wb_data !== 32'h8899AABB) begin bad++; $display("FAIL lw_wb_data got=%h want=8899aabb", wb_data); end
        @(negedge clk); #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL lw_no_accept_valid got=%0h want=0", wb_valid); end
    endtask

    task automatic test_subword_loads();
        logic [3:0]  ops [5];
        logic [31:0] adr [5];
        logic [31:0] exp [5];
        ops[0] = OP_LB;  adr[0] = 32'h13; exp[0] = 32'hFFFFFF88;
        ops[1] = OP_LBU; adr[1] = 32'h13; exp[1] = 32'h00000088;
        ops[2] = OP_LH;  adr[2] = 32'h12; exp[2] = 32'hFFFF8899;
        ops[3] = OP_LHU; adr[3] = 32'h12; exp[3] = 32'h00008899;
        ops[4] = OP_LB;  adr[4] = 32'h11; exp[4] = 32'hFFFFFFAA;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], adr[i], 32'h0, 5'd7, 1'b1);
            @(negedge clk);
            total++; if (wb_data !== exp[i]) begin bad++; $display("FAIL load_%0d_data got=%h want=%h", i, wb_data, exp[i]); end
            total++; if (wb_reg_write !== 1'b1) begin bad++; $display("FAIL load_%0d_reg_write got=%0h want=1", i, wb_reg_write); end
        end
        idle();
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        drive(OP_NONE, 32'h13, 32'hDEADBEEF, 5'd9, 1'b1);
        #1;
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL none_mem got=%0h%0h want=00", mem_read, mem_write); end
        @(negedge clk);
        total++; if (wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL none_data got=%h want=deadbeef", wb_data); end
        total++; if (wb_reg_write !== 1'b1) begin bad++; $display("FAIL none_reg_write got=%0h want=1", wb_reg_write); end
        drive(4'hF, 32'h12, 32'h12345678, 5'd10, 1'b1);
        #1;
        total++; if (mem_read !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL illegal_mem got=%0h%0h want=00", mem_read, stall); end
        @(negedge clk);
        idle();
        total++; if (wb_data !== 32'h12345678) begin bad++; $display("FAIL illegal_data got=%h want=12345678", wb_data); end
        total++; if (wb_rd !== 5'd10) begin bad++; $display("FAIL illegal_rd got=%0d want=10", wb_rd); end
    endtask

    task automatic test_sw();
        @(negedge clk);
        drive(OP_SW, 32'h14, 32'hCAFEF00D, 5'd1, 1'b1);
        #1;
        total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL sw_mem_write got=%0h want=1", mem_write); end
        total++; if (mem_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL sw_mem_wdata got=%h want=cafef00d", mem_wdata); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sw_stall got=%0h want=0", stall); end
        @(negedge clk);
        idle();
        total++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin bad++; $display("FAIL sw_wb got=%0h%0h want=10", wb_valid, wb_reg_write); end
        total++; if (mem[5] !== 32'hCAFEF00D) begin bad++; $display("FAIL sw_memword got=%h want=cafef00d", mem[5]); end
    endtask

    task automatic test_sb_rmw();
        preload(6'd4, 32'h11223344);
        drive(OP_SB, 32'h11, 32'hFFFFFF5A, 5'd2, 1'b1);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_stall1 got=%0h want=1", stall); end
        total++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin bad++; $display("FAIL sb_read_phase got=%0h%0h want=10", mem_read, mem_write); end
        @(negedge clk); #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL sb_stall_no_wb got=%0h want=0", wb_valid); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sb_stall2 got=%0h want=0", stall); end
        total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("FAIL sb_write_phase got=%0h%0h want=10", mem_write, mem_read); end
        total++; if (mem_wdata !== 32'h11225A44) begin bad++; $display("FAIL sb_wdata got=%h want=11225a44", mem_wdata); end
        total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL sb_addr got=%h want=10", mem_addr); end
        @(negedge clk);
        total++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin bad++; $display("FAIL sb_wb got=%0h%0h want=10", wb_valid, wb_reg_write); end
        drive(OP_LW, 32'h10, 32'h0, 5'd3, 1'b1);
        @(negedge clk);
        total++; if (wb_data !== 32'h11225A44) begin bad++; $display("FAIL sb_then_lw got=%h want=11225a44", wb_data); end
        // back-to-back SB then LB to the same word
        drive(OP_SB, 32'h12, 32'h000000A5, 5'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        drive(OP_LB, 32'h12, 32'h0, 5'd4, 1'b1);
        @(negedge clk);
        idle();
        total++; if (wb_data !== 32'hFFFFFFA5) begin bad++; $display("FAIL b2b_lb got=%h want=ffffffa5", wb_data); end
        total++; if (mem[4] !== 32'h11A55A44) begin bad++; $display("FAIL b2b_memword got=%h want=11a55a44", mem[4]); end
    endtask

    task automatic test_misalign();
        @(negedge clk);
        drive(OP_SH, 32'h21, 32'h0000BEEF, 5'd0, 1'b0);
        #1;
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL sh_mis_comb got=%0h%0h%0h want=000", mem_read, mem_write, stall); end
        @(negedge clk);
        total++; if (addr_error !== 1'b1 || wb_valid !== 1'b1) begin bad++; $display("FAIL sh_mis_err got=%0h%0h want=11", addr_error, wb_valid); end
        total++; if (err_addr !== 32'h21) begin bad++; $display("FAIL sh_mis_addr got=%h want=21", err_addr); end
        drive(OP_LW, 32'h22, 32'h0, 5'd6, 1'b1);
        #1;
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL lw_mis_read got=%0h want=0", mem_read); end
        @(negedge clk);
        idle();
        total++; if (addr_error !== 1'b1 || wb_reg_write !== 1'b0) begin bad++; $display("FAIL lw_mis_err got=%0h%0h want=10", addr_error, wb_reg_write); end
        total++; if (err_addr !== 32'h22) begin bad++; $display("FAIL lw_mis_addr got=%h want=22", err_addr); end
        @(negedge clk);
        total++; if (addr_error !== 1'b0) begin bad++; $display("FAIL err_pulse got=%0h want=0", addr_error); end
        total++; if (err_addr !== 32'h22) begin bad++; $display("FAIL err_hold got=%h want=22", err_addr); end
    endtask

    task automatic test_rmw_abort();
        @(negedge clk);
        drive(OP_SH, 32'h30, 32'h0000BEEF, 5'd0, 1'b0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL abort_stall got=%0h want=1", stall); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL abort_mem_write got=%0h want=0", mem_write); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL abort_stall_rst got=%0h want=0", stall); end
        total++; if (wb_data !== 32'h0 || wb_rd !== 5'd0) begin bad++; $display("FAIL abort_wb got=%h/%0d want=0/0", wb_data, wb_rd); end
        total++; if (err_addr !== 32'h0) begin bad++; $display("FAIL abort_err_addr got=%h want=0", err_addr); end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (mem[12] !== 32'h01020304) begin bad++; $display("FAIL abort_memword got=%h want=01020304", mem[12]); end
        drive(OP_LW, 32'h30, 32'h0, 5'd3, 1'b1);
        #1;
        total++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin bad++; $display("FAIL abort_idle got=%0h%0h want=10", mem_read, mem_write); end
        @(negedge clk);
        idle();
        total++; if (wb_data !== 32'h01020304) begin bad++; $display("FAIL abort_lw got=%h want=01020304", wb_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=hang want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lw();
        test_subword_loads();
        test_passthrough();
        test_sw();
        test_sb_rmw();
        test_misalign();
        test_rmw_abort();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
